// File: rtl/xdma_c2h_axis_arbiter.sv
// Packet-level round-robin arbiter merging two C2H AXI-Stream sources into one registered output.
// Optional per-port packet counters are built when XDMA_C2H_ARB_PKT_CNT_EN is defined.
module xdma_c2h_axis_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic                  xdma_clk,
    input  logic                  xdma_reset,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic [USER_WIDTH-1:0] s0_axis_tuser,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic [USER_WIDTH-1:0] s1_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  m_axis_tid,
    output logic [31:0]           pkt_cnt0,
    output logic [31:0]           pkt_cnt1
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  last_served_q, last_served_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
    logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;
    logic                  m_tid_q, m_tid_d;
    logic                  grant0, grant1, can_load, acc0, acc1;

    // In IDLE a lone requester wins; on contention the port that did not finish last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (state_q)
            IDLE: begin
                grant0 = s0_axis_tvalid && (!s1_axis_tvalid || last_served_q);
                grant1 = s1_axis_tvalid && (!s0_axis_tvalid || !last_served_q);
            end
            LOCK0:   grant0 = 1'b1;
            LOCK1:   grant1 = 1'b1;
            default: ;
        endcase
    end

    assign can_load       = !m_tvalid_q || m_axis_tready;
    assign s0_axis_tready = grant0 && can_load && !xdma_reset;
    assign s1_axis_tready = grant1 && can_load && !xdma_reset;
    assign acc0           = s0_axis_tvalid && s0_axis_tready;
    assign acc1           = s1_axis_tvalid && s1_axis_tready;

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        m_tvalid_d    = m_tvalid_q;
        m_tlast_d     = m_tlast_q;
        m_tdata_d     = m_tdata_q;
        m_tkeep_d     = m_tkeep_q;
        m_tuser_d     = m_tuser_q;
        m_tid_d       = m_tid_q;
        if (acc0) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = s0_axis_tlast;
            m_tdata_d  = s0_axis_tdata;
            m_tkeep_d  = s0_axis_tkeep;
            m_tuser_d  = s0_axis_tuser;
            m_tid_d    = 1'b0;
            state_d    = s0_axis_tlast ? IDLE : LOCK0;
            if (s0_axis_tlast) last_served_d = 1'b0;
        end else if (acc1) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = s1_axis_tlast;
            m_tdata_d  = s1_axis_tdata;
            m_tkeep_d  = s1_axis_tkeep;
            m_tuser_d  = s1_axis_tuser;
            m_tid_d    = 1'b1;
            state_d    = s1_axis_tlast ? IDLE : LOCK1;
            if (s1_axis_tlast) last_served_d = 1'b1;
        end else if (m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge xdma_clk) begin
        if (xdma_reset) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            m_tdata_q     <= '0;
            m_tkeep_q     <= '0;
            m_tuser_q     <= '0;
            m_tid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tlast_q     <= m_tlast_d;
            m_tdata_q     <= m_tdata_d;
            m_tkeep_q     <= m_tkeep_d;
            m_tuser_q     <= m_tuser_d;
            m_tid_q       <= m_tid_d;
        end
    end

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tid    = m_tid_q;

`ifdef XDMA_C2H_ARB_PKT_CNT_EN
    logic [31:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [31:0] pkt_cnt1_q, pkt_cnt1_d;

    // Counters wrap naturally at 32 bits.
    always_comb begin
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;
        if (acc0 && s0_axis_tlast) pkt_cnt0_d = pkt_cnt0_q + 32'd1;
        if (acc1 && s1_axis_tlast) pkt_cnt1_d = pkt_cnt1_q + 32'd1;
    end

    always_ff @(posedge xdma_clk) begin
        if (xdma_reset) begin
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
        end
    end

    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
`else
    assign pkt_cnt0 = '0;
    assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_xdma_c2h_axis_arbiter.sv
// Self-checking bench for xdma_c2h_axis_arbiter: grant table, directed corner sequences and a
// randomized run scored against per-port packet queues.
module tb_xdma_c2h_axis_arbiter;

    logic         xdma_clk = 1'b0;
    logic         xdma_reset;
    logic         s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
    logic [511:0] s0_axis_tdata;
    logic [63:0]  s0_axis_tkeep;
    logic [0:0]   s0_axis_tuser;
    logic         s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
    logic [511:0] s1_axis_tdata;
    logic [63:0]  s1_axis_tkeep;
    logic [0:0]   s1_axis_tuser;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [0:0]   m_axis_tuser;
    logic         m_axis_tid;
    logic [31:0]  pkt_cnt0, pkt_cnt1;

    always #5 xdma_clk = ~xdma_clk;

    xdma_c2h_axis_arbiter #(.DATA_WIDTH(512), .KEEP_WIDTH(64), .USER_WIDTH(1)) dut (
        .xdma_clk(xdma_clk), .xdma_reset(xdma_reset),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
        .s0_axis_tlast(s0_axis_tlast), .s0_axis_tdata(s0_axis_tdata),
        .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tuser(s0_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
        .s1_axis_tlast(s1_axis_tlast), .s1_axis_tdata(s1_axis_tdata),
        .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tuser(s1_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tid(m_axis_tid), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         user;
        logic         last;
    } beat_t;

    typedef struct {
        logic v0, v1, mr;
        logic er0, er1;
    } gvec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t bq0[$];
    beat_t bq1[$];
    int    out_tids[$];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic beat_t mk_beat(input logic last);
        beat_t b;
        b.data = rnd512();
        b.keep = {$urandom, $urandom};
        b.user = 1'($urandom_range(1));
        b.last = last;
        return b;
    endfunction

    // len 0 means random length 1..4
    task automatic gen_pkts(input int port, input int npkt, input int len);
        for (int p = 0; p < npkt; p++) begin
            int l;
            l = (len == 0) ? int'($urandom_range(4, 1)) : len;
            for (int k = 0; k < l; k++) begin
                if (port == 0) bq0.push_back(mk_beat(k == l - 1));
                else           bq1.push_back(mk_beat(k == l - 1));
            end
        end
    endtask

    task automatic drive(input int port, input beat_t b);
        if (port == 0) begin
            s0_axis_tvalid = 1'b1; s0_axis_tdata = b.data; s0_axis_tkeep = b.keep;
            s0_axis_tuser = b.user; s0_axis_tlast = b.last;
        end else begin
            s1_axis_tvalid = 1'b1; s1_axis_tdata = b.data; s1_axis_tkeep = b.keep;
            s1_axis_tuser = b.user; s1_axis_tlast = b.last;
        end
    endtask

    task automatic do_reset();
        @(negedge xdma_clk);
        xdma_reset = 1'b1;
        s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        bq0.delete(); bq1.delete(); out_tids.delete();
        @(negedge xdma_clk);
        xdma_reset = 1'b0;
    endtask

    task automatic chk_beat(input string nm, input beat_t b, input logic tid);
        chk({nm, "_vld"},  m_axis_tvalid, 1'b1);
        chk({nm, "_tid"},  m_axis_tid,    tid);
        chk({nm, "_data"}, m_axis_tdata,  b.data);
        chk({nm, "_keep"}, m_axis_tkeep,  b.keep);
        chk({nm, "_last"}, m_axis_tlast,  b.last);
    endtask

    // Drives queued beats and scores every output handshake against the per-port queues.
    task automatic run_traffic(input int pv, input int pr, input int max_cyc, output int gaps);
        int i0, i1, e0, e1, lock, cyc, first_hs, last_hs, n_hs;
        bit hs0, hs1;
        i0 = 0; i1 = 0; e0 = 0; e1 = 0; lock = -1; cyc = 0;
        first_hs = -1; last_hs = -1; n_hs = 0; hs0 = 0; hs1 = 0;
        while ((e0 < bq0.size() || e1 < bq1.size()) && cyc < max_cyc) begin
            @(negedge xdma_clk);
            cyc++;
            if (hs0) begin i0++; s0_axis_tvalid = 1'b0; end
            if (hs1) begin i1++; s1_axis_tvalid = 1'b0; end
            if (!s0_axis_tvalid && i0 < bq0.size() && $urandom_range(99) < pv) drive(0, bq0[i0]);
            if (!s1_axis_tvalid && i1 < bq1.size() && $urandom_range(99) < pv) drive(1, bq1[i1]);
            m_axis_tready = ($urandom_range(99) < pr);
            #1;
            hs0 = s0_axis_tvalid && s0_axis_tready;
            hs1 = s1_axis_tvalid && s1_axis_tready;
            if (m_axis_tvalid && m_axis_tready) begin
                int t;
                beat_t b;
                t = m_axis_tid ? 1 : 0;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                n_hs++;
                out_tids.push_back(t);
                n_tests++;
                if (lock >= 0 && lock != t) begin
                    n_fail++;
                    $display("FAIL sb_interleave: got tid %0d expected %0d", t, lock);
                end else if ((t == 0 && e0 >= bq0.size()) || (t == 1 && e1 >= bq1.size())) begin
                    n_fail++;
                    $display("FAIL sb_extra_beat: got beat on tid %0d expected none", t);
                end else begin
                    b = (t == 0) ? bq0[e0] : bq1[e1];
                    if (m_axis_tdata !== b.data || m_axis_tkeep !== b.keep ||
                        m_axis_tuser !== b.user || m_axis_tlast !== b.last) begin
                        n_fail++;
                        $display("FAIL sb_beat port%0d idx %0d: got last %0b data %0h expected last %0b data %0h",
                                 t, (t == 0) ? e0 : e1, m_axis_tlast, m_axis_tdata, b.last, b.data);
                    end
                    if (t == 0) e0++; else e1++;
                    lock = b.last ? -1 : t;
                end
            end
        end
        if (cyc >= max_cyc) begin
            n_tests++; n_fail++;
            $display("FAIL sb_timeout: got %0d/%0d beats expected %0d/%0d", e0, e1, bq0.size(), bq1.size());
        end
        gaps = (n_hs == 0) ? 0 : (last_hs - first_hs + 1 - n_hs);
        @(negedge xdma_clk);
        s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gvec_t tbl[8];
        beat_t b[4];
        int    gaps;

        tbl[0] = '{0, 0, 1, 0, 0};
        tbl[1] = '{1, 0, 1, 1, 0};
        tbl[2] = '{0, 1, 1, 0, 1};
        tbl[3] = '{1, 1, 1, 1, 0};
        tbl[4] = '{0, 0, 0, 0, 0};
        tbl[5] = '{1, 0, 0, 1, 0};
        tbl[6] = '{0, 1, 0, 0, 1};
        tbl[7] = '{1, 1, 0, 1, 0};

        s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tuser = '0; s0_axis_tlast = 1'b0;
        s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tuser = '0; s1_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;

        // Reset state, with both sources requesting during reset
        xdma_reset = 1'b1;
        s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1;
        @(negedge xdma_clk);
        @(negedge xdma_clk);
        #1;
        chk("rst_s0_ready", s0_axis_tready, 1'b0);
        chk("rst_s1_ready", s1_axis_tready, 1'b0);
        chk("rst_m_valid",  m_axis_tvalid,  1'b0);
        chk("rst_m_last",   m_axis_tlast,   1'b0);
        chk("rst_m_data",   m_axis_tdata,   '0);
        chk("rst_m_keep",   m_axis_tkeep,   '0);
        chk("rst_m_user",   m_axis_tuser,   '0);
        chk("rst_m_tid",    m_axis_tid,     1'b0);
        chk("rst_cnt0",     pkt_cnt0,       '0);
        chk("rst_cnt1",     pkt_cnt1,       '0);
        do_reset();

        // IDLE grant table straight after reset (port 0 preferred on contention)
        for (int i = 0; i < 8; i++) begin
            @(negedge xdma_clk);
            s0_axis_tvalid = tbl[i].v0; s1_axis_tvalid = tbl[i].v1; m_axis_tready = tbl[i].mr;
            #1;
            chk($sformatf("grant_tbl%0d_r0", i), s0_axis_tready, tbl[i].er0);
            chk($sformatf("grant_tbl%0d_r1", i), s1_axis_tready, tbl[i].er1);
            #1;
            s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
        end
        m_axis_tready = 1'b1;

        // Port 1 sends a 3-beat packet alone
        do_reset();
        for (int k = 0; k < 3; k++) b[k] = mk_beat(k == 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge xdma_clk);
            if (k > 0) chk_beat($sformatf("p1pkt_b%0d", k - 1), b[k - 1], 1'b1);
            drive(1, b[k]);
            #1;
            chk($sformatf("p1pkt_r1_%0d", k), s1_axis_tready, 1'b1);
            chk($sformatf("p1pkt_r0_%0d", k), s0_axis_tready, 1'b0);
        end
        @(negedge xdma_clk);
        chk_beat("p1pkt_b2", b[2], 1'b1);
        s1_axis_tvalid = 1'b0;
        @(negedge xdma_clk);
        chk("p1pkt_drain", m_axis_tvalid, 1'b0);
`ifdef XDMA_C2H_ARB_PKT_CNT_EN
        chk("p1pkt_cnt1", pkt_cnt1, 32'd1);
`else
        chk("p1pkt_cnt1", pkt_cnt1, 32'd0);
`endif
        chk("p1pkt_cnt0", pkt_cnt0, 32'd0);

        // Both ports stream 2-beat packets: strict alternation, no bubbles
        do_reset();
        gen_pkts(0, 4, 2);
        gen_pkts(1, 4, 2);
        run_traffic(100, 100, 200, gaps);
        chk("rr_gaps", gaps, 0);
        chk("rr_count", out_tids.size(), 16);
        for (int i = 0; i < 16 && i < out_tids.size(); i++)
            chk($sformatf("rr_order%0d", i), out_tids[i], (i / 2) % 2);

        // Port 0 stalls mid-packet while port 1 waits
        do_reset();
        b[0] = mk_beat(1'b0); b[1] = mk_beat(1'b1); b[2] = mk_beat(1'b1);
        @(negedge xdma_clk);
        drive(0, b[0]); drive(1, b[2]);
        for (int k = 0; k < 4; k++) begin
            @(negedge xdma_clk);
            s0_axis_tvalid = 1'b0;
            #1;
            chk($sformatf("stall_r1_%0d", k), s1_axis_tready, 1'b0);
        end
        @(negedge xdma_clk);
        drive(0, b[1]);
        #1;
        chk("stall_r1_resume", s1_axis_tready, 1'b0);
        chk("stall_r0_resume", s0_axis_tready, 1'b1);
        @(negedge xdma_clk);
        chk_beat("stall_p0_tail", b[1], 1'b0);
        s0_axis_tvalid = 1'b0;
        #1;
        chk("stall_r1_after", s1_axis_tready, 1'b1);
        @(negedge xdma_clk);
        chk_beat("stall_p1", b[2], 1'b1);
        s1_axis_tvalid = 1'b0;

        // Output back-pressure for 5 cycles with a beat pending
        do_reset();
        b[0] = mk_beat(1'b0); b[1] = mk_beat(1'b1); b[2] = mk_beat(1'b1);
        @(negedge xdma_clk);
        drive(0, b[0]);
        @(negedge xdma_clk);
        m_axis_tready = 1'b0;
        drive(0, b[1]); drive(1, b[2]);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk_beat($sformatf("bp_hold%0d", k), b[0], 1'b0);
            chk($sformatf("bp_r0_%0d", k), s0_axis_tready, 1'b0);
            chk($sformatf("bp_r1_%0d", k), s1_axis_tready, 1'b0);
            @(negedge xdma_clk);
        end
        m_axis_tready = 1'b1;
        #1;
        chk("bp_r0_release", s0_axis_tready, 1'b1);
        @(negedge xdma_clk);
        chk_beat("bp_b1", b[1], 1'b0);
        s0_axis_tvalid = 1'b0;
        @(negedge xdma_clk);
        chk_beat("bp_p1", b[2], 1'b1);
        s1_axis_tvalid = 1'b0;
        @(negedge xdma_clk);
        chk("bp_drain", m_axis_tvalid, 1'b0);

        // Reset on the 2nd beat of a 4-beat port 0 packet
        do_reset();
        for (int k = 0; k < 4; k++) b[k] = mk_beat(k == 3);
        @(negedge xdma_clk);
        drive(0, b[0]);
        @(negedge xdma_clk);
        drive(0, b[1]);
        xdma_reset = 1'b1;
        #1;
        chk("midrst_r0_in_reset", s0_axis_tready, 1'b0);
        @(negedge xdma_clk);
        xdma_reset = 1'b0;
        s0_axis_tvalid = 1'b0;
        drive(1, b[3]);
        #1;
        chk("midrst_m_valid", m_axis_tvalid, 1'b0);
        chk("midrst_idle_r1", s1_axis_tready, 1'b1);
        drive(0, b[2]);
        s0_axis_tlast = 1'b1;
        #1;
        chk("midrst_both_r0", s0_axis_tready, 1'b1);
        chk("midrst_both_r1", s1_axis_tready, 1'b0);
        @(negedge xdma_clk);
        chk("midrst_first_tid", m_axis_tid, 1'b0);
        chk("midrst_first_data", m_axis_tdata, b[2].data);
        s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;

        // Randomized traffic with back-pressure against the packet scoreboard
        do_reset();
        gen_pkts(0, 25, 0);
        gen_pkts(1, 25, 0);
        run_traffic(60, 70, 4000, gaps);

`ifdef XDMA_C2H_ARB_PKT_CNT_EN
        // Counter wrap
        do_reset();
        @(negedge xdma_clk);
        force dut.pkt_cnt0_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt0_q;
        chk("wrap_preload", pkt_cnt0, 32'hFFFF_FFFF);
        drive(0, mk_beat(1'b1));
        @(negedge xdma_clk);
        s0_axis_tvalid = 1'b0;
        chk("wrap_cnt0", pkt_cnt0, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xdma_c2h_axis_arbiter.md
# xdma_c2h_axis_arbiter

Packet-level round-robin arbiter that shares the single XDMA C2H AXI-Stream (512-bit) between two UDP/IP/ARP/Ethernet/CMAC receive paths, so both QSFP ports can deliver frames to the host. It sits in the `xdma_clk` domain, between the two receive-wrapper C2H outputs and the XDMA `s_axis_c2h_*_0` inputs. It has one registered output stage.

## Interface
Parameters:
- `DATA_WIDTH`, 512: tdata width.
- `KEEP_WIDTH`, 64: tkeep width; equals `DATA_WIDTH/8`.
- `USER_WIDTH`, 1: tuser width.

Ports:
- `xdma_clk`  in  1  sole clock.
- `xdma_reset`  in  1  synchronous, active-high reset.
- `s0_axis_tvalid` / `s0_axis_tready` / `s0_axis_tlast`  in / out / in  1  port 0 handshake and end of packet.
- `s0_axis_tdata` / `s0_axis_tkeep` / `s0_axis_tuser`  in  `DATA_WIDTH` / `KEEP_WIDTH` / `USER_WIDTH`  port 0 payload.
- `s1_axis_*`  same directions and widths as `s0_axis_*`  port 1 stream.
- `m_axis_tvalid` / `m_axis_tready` / `m_axis_tlast`  out / in / out  1  merged stream handshake toward XDMA C2H.
- `m_axis_tdata` / `m_axis_tkeep` / `m_axis_tuser`  out  widths as above  merged payload.
- `m_axis_tid`  out  1  index of the source port for the current beat.
- `pkt_cnt0`, `pkt_cnt1`  out  32  packets forwarded per port (see Configuration).

## Operation
- FSM states:
  - `IDLE`: no packet locked.
  - `LOCK0`: port 0 owns the output until its tlast.
  - `LOCK1`: port 1 owns the output until its tlast.
- `last_served` register records the port that completed the most recent packet. Reset value is 1, so port 0 wins first.
- Output stage:
  - `can_load = !m_axis_tvalid || m_axis_tready`.
  - Only the granted port sees `sN_axis_tready = can_load`. The other port's tready is 0.
- Grant in `IDLE` is combinational:
  - Only one port valid → that port is granted.
  - Both ports valid → the port `!= last_served` is granted.
  - Neither port valid → no grant.
- On an accepted beat (`sN_axis_tvalid && sN_axis_tready`):
  - The beat is loaded into the output register, with `m_axis_tid = N`.
  - From `IDLE`: next state is `LOCKN` if tlast=0. If tlast=1 (single-beat packet), stay in `IDLE` and set `last_served = N`.
  - From `LOCKN` with tlast=1: go to `IDLE` and set `last_served = N`.
- While in `LOCKN`, the other port is never granted, regardless of its valid.
- Output register clears `m_axis_tvalid` when `m_axis_tready=1` and no new beat loads.
- Payload is never modified. tkeep and tuser pass through verbatim.
- Reset mid-packet:
  - The partial packet is abandoned and no further beats of it are forwarded.
  - The upstream is responsible for frame resync.

## Timing
- Reset values: `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `m_axis_tkeep=0`, `m_axis_tuser=0`, `m_axis_tid=0`, `s0/s1_axis_tready=0` during reset, FSM=`IDLE`, `last_served=1`, counters=0.
- Latency: an accepted input beat appears on `m_axis_*` in the next cycle.
- Throughput: 1 beat/cycle while `m_axis_tready=1`.
- Packet boundaries add no bubble: a tlast accept in cycle T allows the other port's first beat to be accepted in cycle T+1.
- `sN_axis_tready` depends combinationally on `m_axis_tready`. There is no skid buffer.
- `m_axis_*` stays stable while `m_axis_tvalid=1 && m_axis_tready=0` (AXIS rule).
- Input valid deasserting mid-packet holds the lock. The lock releases only on tlast.

## Configuration
- Macro: `XDMA_C2H_ARB_PKT_CNT_EN`.
- Defined:
  - `pkt_cnt0`/`pkt_cnt1` increment by 1 on each accepted tlast beat from the matching port.
  - 32-bit counters, wrapping 0xFFFFFFFF → 0.
  - Cleared by `xdma_reset`.
- Undefined:
  - Counter registers are not built.
  - `pkt_cnt0`/`pkt_cnt1` are tied to 0, so the port list is identical in both builds.

## Test plan
- After reset, port 1 sends a 3-beat packet with port 0 idle and `m_axis_tready=1` → 3 beats out on cycles T+1..T+3 with `m_axis_tid=1` and tlast on the 3rd. If enabled, `pkt_cnt1=1`.
- Both ports present 2-beat packets continuously → output order 0,0,1,1,0,0,1,1 with no idle cycles and tid matching each packet.
- Port 0 drops tvalid for 4 cycles mid-packet while port 1 is valid → port 1 tready stays 0 and port 0's packet resumes and completes before any port 1 beat.
- `m_axis_tready` held 0 for 5 cycles with a beat pending → `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` stay constant, both s tready=0, and no beat is lost or duplicated.
- `xdma_reset` pulsed on the 2nd beat of a 4-beat port 0 packet → the following cycle `m_axis_tvalid=0` and FSM is `IDLE`. With both ports then valid, port 0 is granted first.
- With `XDMA_C2H_ARB_PKT_CNT_EN`, preload via force `pkt_cnt0=0xFFFFFFFF` and send one single-beat port 0 packet → `pkt_cnt0=0`.
